// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and req/ack instruction-fetch sequencer with branch/jump redirect.
// Optional feature: define BRANCH_COUNT_EN to add the saturating branch_count port.
module pc_fetch_unit #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
`ifdef BRANCH_COUNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pcsrc,
   input  logic [15:0]      branch_offset,
   input  logic             jump,
   input  logic [25:0]      jump_addr,
   input  logic             stall,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      instr,
   output logic             instr_valid,
   output logic [WIDTH-1:0] instr_pc,
   output logic [WIDTH-1:0] pc_plus4
`ifdef BRANCH_COUNT_EN
   , output logic [CNT_W-1:0] branch_count
`endif
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] pc, pend_tgt, target, branch_tgt, jump_tgt;
   logic pend, redirect, deliver, settle;
   assign imem_req  = state == BUSY;
   assign imem_addr = pc;
   // next state, redirect target and delivery decision
   always_comb begin
      redirect   = pcsrc | jump;
      branch_tgt = pc_plus4 + ({{(WIDTH-16){branch_offset[15]}}, branch_offset} << 2);
      jump_tgt   = (pc_plus4 & ({WIDTH{1'b1}} << 28)) | WIDTH'({jump_addr, 2'b00});
      target     = jump ? jump_tgt : branch_tgt;
      settle     = state == IDLE || imem_ack;
      deliver    = state == BUSY && imem_ack && !redirect && !pend;
      state_n    = settle ? (stall ? IDLE : BUSY) : BUSY;
   end
   // fetch state register; reset drops the request immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end
   // pc, pending redirect and delivered-instruction registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         pend        <= 1'b0;
         pend_tgt    <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
         instr_pc    <= RESET_PC;
         pc_plus4    <= RESET_PC + WIDTH'(4);
      end else begin
         instr_valid <= deliver;
         pend_tgt    <= redirect ? target : pend_tgt;
         if (state == BUSY) pend <= imem_ack ? 1'b0 : pend | redirect;
         if (deliver) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
            pc_plus4 <= pc + WIDTH'(4);
            pc       <= pc + WIDTH'(4);
         end else if (settle) begin
            pc <= redirect ? target : pend ? pend_tgt : pc;
         end
      end
   end
`ifdef BRANCH_COUNT_EN
   // saturating count of cycles with an accepted redirect
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        branch_count <= '0;
      else if (redirect && ~&branch_count) branch_count <= branch_count + 1'b1;
   end
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and random fetch/redirect checks against a transaction-level model.
module tb_pc_fetch_unit;
   logic clk = 0, reset = 0, pcsrc = 0, jump = 0, stall = 1, imem_ack = 0;
   logic [15:0] branch_offset = '0;
   logic [25:0] jump_addr = '0;
   logic [31:0] imem_rdata = '0;
   logic imem_req, instr_valid;
   logic [31:0] imem_addr, instr, instr_pc, pc_plus4;
`ifdef BRANCH_COUNT_EN
   logic [15:0] branch_count;
`endif
   int vectors = 0, miscompares = 0;
   bit m_busy, m_pend, e_valid;
   logic [31:0] m_addr, m_ptgt, e_instr, e_ipc;
   int m_cnt, age;
   logic [31:0] dpcs[$];

   pc_fetch_unit dut (
      .clk(clk), .reset(reset), .pcsrc(pcsrc), .branch_offset(branch_offset),
      .jump(jump), .jump_addr(jump_addr), .stall(stall), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc), .pc_plus4(pc_plus4)
`ifdef BRANCH_COUNT_EN
      , .branch_count(branch_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_init();
      m_busy = 0; m_pend = 0; m_addr = 0; m_ptgt = 0;
      e_valid = 0; e_instr = 0; e_ipc = 0; m_cnt = 0; age = 0;
   endtask

   task automatic do_reset();
      reset = 1; pcsrc = 0; jump = 0; stall = 1; imem_ack = 1;
      #1;
      chk("rst_req", {31'b0, imem_req}, 0);
      chk("rst_valid", {31'b0, instr_valid}, 0);
      chk("rst_instr", instr, 0);
      chk("rst_ipc", instr_pc, 0);
      chk("rst_pc4", pc_plus4, 4);
`ifdef BRANCH_COUNT_EN
      chk("rst_bcnt", 32'(branch_count), 0);
`endif
      @(posedge clk); @(posedge clk); #1;
      imem_ack = 0; reset = 0;
      model_init();
   endtask

   // one clock: apply inputs, compare outputs with the model, then advance the model
   task automatic step(input bit p, input logic [15:0] off, input bit j,
                       input logic [25:0] ja, input bit st, input bit ak);
      logic [31:0] p4, tgt;
      int so;
      bit redir;
      pcsrc = p; branch_offset = off; jump = j; jump_addr = ja; stall = st;
      imem_ack = ak && m_busy;
      imem_rdata = imem_ack ? ~m_addr : $urandom;
      chk("req", {31'b0, imem_req}, {31'b0, m_busy});
      if (m_busy) chk("addr", imem_addr, m_addr);
      chk("valid", {31'b0, instr_valid}, {31'b0, e_valid});
      chk("instr", instr, e_instr);
      chk("ipc", instr_pc, e_ipc);
      chk("pc4", pc_plus4, e_ipc + 4);
`ifdef BRANCH_COUNT_EN
      chk("bcnt", 32'(branch_count), 32'(m_cnt));
`endif
      if (instr_valid === 1'b1) dpcs.push_back(instr_pc);
      redir = p | j;
      p4 = e_ipc + 4;
      so = int'($signed(off));
      tgt = j ? ((p4 & 32'hF000_0000) | (32'(ja) * 4)) : p4 + 32'(so * 4);
      if (redir && m_cnt < 65535) m_cnt++;
      age = (m_busy && !imem_ack) ? age + 1 : 0;
      e_valid = 0;
      if (!m_busy) begin
         if (redir) m_addr = tgt;
         m_busy = !st;
      end else if (imem_ack) begin
         if (redir) m_addr = tgt;
         else if (m_pend) m_addr = m_ptgt;
         else begin
            e_valid = 1; e_instr = imem_rdata; e_ipc = m_addr; m_addr = m_addr + 4;
         end
         m_pend = 0;
         m_busy = !st;
      end else if (redir) begin
         m_pend = 1; m_ptgt = tgt;
      end
      @(posedge clk); #1;
   endtask

   task automatic go(input int n, input bit st, input int lat);
      repeat (n) step(0, 0, 0, 0, st, age >= lat);
   endtask

   initial begin
      model_init();
      do_reset();
      // sequential fetch 0,4,8 with ack one cycle after each request
      go(8, 0, 1);
      chk("seq_n", dpcs.size(), 3);
      if (dpcs.size() >= 3) begin
         chk("seq0", dpcs[0], 0); chk("seq1", dpcs[1], 4); chk("seq2", dpcs[2], 8);
      end
      go(4, 1, 1);
      // branch back from instr_pc 0x40 while idle
      step(0, 0, 1, 26'h10, 1, 0);
      go(1, 0, 1); go(2, 1, 1); go(1, 1, 1);
      chk("ipc40", instr_pc, 32'h40);
      step(1, 16'hFFFE, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("br_addr", imem_addr, 32'h3C);
      // jump and branch together while busy: jump wins, word dropped, ack 3 cycles later
      step(1, 16'h0005, 1, 26'h100, 0, 0);
      step(0, 0, 0, 0, 0, 0); chk("hold1", imem_addr, 32'h3C);
      step(0, 0, 0, 0, 0, 0); chk("hold2", imem_addr, 32'h3C);
      step(0, 0, 0, 0, 0, 1);
      chk("drop_valid", {31'b0, instr_valid}, 0);
      chk("jmp_addr", imem_addr, 32'h400);
      // ack withheld 5 cycles while stall toggles
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, i[0], 0);
         chk("stable_req", {31'b0, imem_req}, 1);
         chk("stable_addr", imem_addr, 32'h400);
      end
      step(0, 0, 0, 0, 0, 1);
      chk("ipc400", instr_pc, 32'h400);
      // reach 0xFFFFFFFC by a backward branch and wrap to 0
      step(0, 0, 1, 0, 1, 0);
      go(3, 1, 1); go(1, 0, 1); go(2, 1, 1); go(1, 1, 1);
      step(1, 16'hFFFE, 0, 0, 0, 0);
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      go(2, 0, 1);
      chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc_plus4, 0);
      chk("wrap_next", imem_addr, 0);
      // reset while busy drops the request at once
      step(0, 0, 0, 0, 0, 0);
      do_reset();
`ifdef BRANCH_COUNT_EN
      repeat (3) step(1, 0, 0, 0, 1, 0);
      chk("bcnt3", 32'(branch_count), 3);
      do_reset();
`endif
      step(0, 0, 0, 0, 0, 0);
      chk("post_rst_req", {31'b0, imem_req}, 1);
      chk("post_rst_addr", imem_addr, 0);
      // randomized traffic
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 9) == 0,
              26'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
